// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_map_pkg
//  Description : Shared memory-map constants for the data memory and the
//                control unit: MMIO base, MMIO register offsets, funct3
//                load/store encodings and the MMIO register decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

    // Upper address half that selects the MMIO region
    localparam logic [15:0] c_mmio_base_hi = 16'hFFFF;

    // MMIO register byte offsets within the region
    localparam logic [15:0] c_off_cycle = 16'h0000;
    localparam logic [15:0] c_off_led   = 16'h0004;
    localparam logic [15:0] c_off_fault = 16'h0008;

    // funct3 encodings (loads and stores share the low codes)
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        MMIO_CYCLE = 2'd0,
        MMIO_LED   = 2'd1,
        MMIO_FAULT = 2'd2,
        MMIO_NONE  = 2'd3
    } mmio_sel_e;

    // Registers are decoded on word offset, so any byte within a register's
    // word selects that register.
    function automatic mmio_sel_e decode_mmio(input logic [13:0] word_off);
        mmio_sel_e sel;
        if (word_off == c_off_cycle[15:2])
            sel = MMIO_CYCLE;
        else if (word_off == c_off_led[15:2])
            sel = MMIO_LED;
        else if (word_off == c_off_fault[15:2])
            sel = MMIO_FAULT;
        else
            sel = MMIO_NONE;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Combinational load lane extraction and sign/zero extension.
//  Ports       : i_word     - raw 32-bit word read from RAM/MMIO
//                i_byte_off - Adr[1:0] of the access
//                i_funct3   - load size/sign code
//                o_data     - right-aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
    import mem_map_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_byte_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword lane follows Adr[1] only; an odd halfword address is not an
    // error on the read side.
    assign w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            c_f3_b:  o_data = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: o_data = {24'd0, w_byte};
            c_f3_h:  o_data = {{16{w_half[15]}}, w_half};
            c_f3_hu: o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mmio_memory.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_memory
//  Description : Unified data memory for a multicycle RISC-V core: word RAM
//                with byte/half/word stores plus an MMIO region holding a
//                free-running cycle counter, an LED register and a sticky
//                store-fault capture.
//  Ports       : clk       - clock, all state on rising edge
//                rst       - synchronous active-high reset
//                Adr       - byte address
//                MemWrite  - store strobe
//                WriteData - right-aligned store data
//                funct3    - access size/sign code
//                ReadData  - formatted load data (combinational)
//                leds      - LED register
//                mem_fault - sticky store-fault flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_memory #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adr,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        mem_fault
);
    import mem_map_pkg::*;

    localparam int c_aw = $clog2(DEPTH_WORDS);

    logic [31:0] r_ram [DEPTH_WORDS];
    logic [31:0] r_cycle;
    logic [7:0]  r_leds;
    logic        r_fault;
    logic [31:0] r_fault_adr;

    logic [c_aw-1:0] w_idx;
    logic            w_is_mmio;
    mmio_sel_e       w_sel;
    logic [3:0]      w_mask;
    logic [31:0]     w_wdata;
    logic            w_align_ok;
    logic            w_target_ok;
    logic            w_store;
    logic            w_fault;
    logic            w_commit;
    logic            w_ram_we;
    logic            w_led_we;
    logic [31:0]     w_mmio_word;
    logic [31:0]     w_raw;
    logic [31:0]     w_fmt;

    // Upper address bits beyond the RAM size are dropped, so RAM aliases.
    assign w_idx     = Adr[c_aw+1:2];
    assign w_is_mmio = (Adr[31:16] == c_mmio_base_hi);
    assign w_sel     = decode_mmio(Adr[15:2]);

    // Store lane mask and lane-replicated data; replication lets every lane
    // pick its byte from the same position regardless of offset.
    always_comb begin
        w_mask     = 4'b0000;
        w_wdata    = 32'd0;
        w_align_ok = 1'b0;
        case (funct3)
            c_f3_b: begin
                w_align_ok = 1'b1;
                w_mask     = 4'b0001 << Adr[1:0];
                w_wdata    = {4{WriteData[7:0]}};
            end
            c_f3_h: begin
                w_align_ok = ~Adr[0];
                w_mask     = Adr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{WriteData[15:0]}};
            end
            c_f3_w: begin
                w_align_ok = (Adr[1:0] == 2'b00);
                w_mask     = 4'b1111;
                w_wdata    = WriteData;
            end
            default: begin
                w_align_ok = 1'b0;
            end
        endcase
    end

    // Only the LED register is writable inside the MMIO region.
    assign w_target_ok = !w_is_mmio || (w_sel == MMIO_LED);
    assign w_store     = MemWrite && !rst;
    assign w_fault     = w_store && !(w_align_ok && w_target_ok);
    assign w_commit    = w_store && w_align_ok && w_target_ok;
    assign w_ram_we    = w_commit && !w_is_mmio;
    // LED holds bits 7:0 of its word, i.e. lane 0.
    assign w_led_we    = w_commit && w_is_mmio && w_mask[0];

    // RAM has no reset so a mid-program reset keeps the image.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b])
                    r_ram[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle     <= 32'd0;
            r_leds      <= 8'd0;
            r_fault     <= 1'b0;
            r_fault_adr <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_led_we)
                r_leds <= w_wdata[7:0];
            if (w_fault) begin
                r_fault <= 1'b1;
                // Keep the address of the first fault only.
                if (!r_fault)
                    r_fault_adr <= Adr;
            end
        end
    end

    always_comb begin
        w_mmio_word = 32'd0;
        case (w_sel)
            MMIO_CYCLE: w_mmio_word = r_cycle;
            MMIO_LED:   w_mmio_word = {24'd0, r_leds};
            MMIO_FAULT: w_mmio_word = r_fault_adr;
            default:    w_mmio_word = 32'd0;
        endcase
    end

    assign w_raw = w_is_mmio ? w_mmio_word : r_ram[w_idx];

    load_formatter u_load_formatter (
        .i_word     (w_raw),
        .i_byte_off (Adr[1:0]),
        .i_funct3   (funct3),
        .o_data     (w_fmt)
    );

    assign ReadData  = rst ? 32'd0 : w_fmt;
    assign leds      = r_leds;
    assign mem_fault = r_fault;

endmodule
`default_nettype wire
